// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_div;

  always_comb begin
    w_shift = {i_rem, i_bit};
    w_div   = {2'b00, i_div};
    o_qbit  = (w_shift >= w_div);
    o_rem   = o_qbit ? (WIDTH+1)'(w_shift - w_div) : (WIDTH+1)'(w_shift);
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock), unsigned or signed,
// with start/busy/done handshake and divide-by-zero flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  seq_divider_if.slave bus
);
  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LP_ITERS = CW'(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_a_fix;

  always_comb begin
    w_sgn   = SIGNED_EN && bus.signed_mode;
    w_a_neg = w_sgn && bus.dividend[WIDTH-1];
    w_b_neg = w_sgn && bus.divisor[WIDTH-1];
    w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
    w_b_mag = w_b_neg ? -bus.divisor  : bus.divisor;
    // r_a ends CALC holding the quotient magnitude; untouched on the divide-by-zero path
    w_q_fix = r_neg_q ? -r_a : r_a;
    w_a_fix = r_neg_r ? -r_a : r_a;
    w_r_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_a[WIDTH-1]),
    .i_div  (r_b),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= LP_ITERS;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_state <= (bus.divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_a   <= {r_a[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          if (r_b == '0) begin
            r_q   <= '1;
            r_r   <= w_a_fix;
            r_dbz <= 1'b1;
          end else begin
            r_q <= w_q_fix;
            r_r <= w_r_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 32;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sm) begin
      longint sa = $signed(a);
      longint sb = $signed(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Drive a request now; it is accepted at the next rising edge, then operands are scrambled.
  task automatic launch(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.signed_mode = sm; bus.dividend = a; bus.divisor = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
  endtask

  task automatic wait_done(input int poke_at, output int n, output logic [W-1:0] q,
                           output logic [W-1:0] r, output logic z, output bit busy_ok);
    n = 0; q = 'x; r = 'x; z = 1'bx; busy_ok = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) begin
        n = i; q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (i == poke_at) begin
        bus.start = 1'b1; bus.signed_mode = $urandom_range(0, 1);
        bus.dividend = $urandom; bus.divisor = $urandom_range(1, 9);
      end else if (i == poke_at + 1) begin
        bus.start = 1'b0;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_divisor(input logic sm);
    logic [W-1:0] b;
    case ($urandom_range(0, 7))
      0:       b = '0;
      1, 2, 3: b = W'($urandom_range(1, 20));
      default: b = $urandom;
    endcase
    if (sm && $urandom_range(0, 1) == 1) b = -b;
    return b;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", bus.quotient); end
    n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic         sm [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] a  [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd50};
    logic [W-1:0] b  [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd50};
    logic [W-1:0] eq [6] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    logic [W-1:0] er [6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0};
    int n; logic [W-1:0] q, r; logic z; bit bok;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      launch(sm[k], a[k], b[k]);
      wait_done(0, n, q, r, z, bok);
      n_checks++; if (q !== eq[k]) begin n_fail++; $display("FAIL dir%0d_q: got %h expected %h", k, q, eq[k]); end
      n_checks++; if (r !== er[k]) begin n_fail++; $display("FAIL dir%0d_r: got %h expected %h", k, r, er[k]); end
      n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dbz: got %b expected 0", k, z); end
      n_checks++; if (n !== W + 1) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, n, W + 1); end
      n_checks++; if (!bok) begin n_fail++; $display("FAIL dir%0d_busy: got busy profile wrong expected high until done", k); end
    end
  endtask

  task automatic test_div_zero();
    int n; logic [W-1:0] q, r; logic z; bit bok;
    @(negedge clock);
    launch(1'b0, 32'h1234, 32'd0);
    wait_done(0, n, q, r, z, bok);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 1", n); end
    n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_q: got %h expected ffffffff", q); end
    n_checks++; if (r !== 32'h1234) begin n_fail++; $display("FAIL dbz_r: got %h expected 00001234", r); end
    n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", z); end
    @(posedge clock); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse: got done=%b expected 0", bus.done); end
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold: got %b expected 1", bus.div_by_zero); end
    @(negedge clock);
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got %b expected 0", bus.div_by_zero); end
    n_checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_qhold: got %h expected ffffffff", bus.quotient); end
    wait_done(0, n, q, r, z, bok);
    n_checks++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || z !== 1'b0) begin
      n_fail++; $display("FAIL dbz_next: got q=%h r=%h z=%b expected fffffffd ffffffff 0", q, r, z); end
  endtask

  task automatic test_random();
    int n; logic [W-1:0] q, r, a, b, eq, er; logic z, ez, sm; bit bok;
    for (int k = 0; k < 40; k++) begin
      sm = k[0];
      a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      b  = rand_divisor(sm);
      model(sm, a, b, eq, er, ez);
      @(negedge clock);
      launch(sm, a, b);
      wait_done(0, n, q, r, z, bok);
      n_checks++; if (q !== eq || r !== er || z !== ez) begin
        n_fail++; $display("FAIL rand%0d: s=%b %h/%h got q=%h r=%h z=%b expected q=%h r=%h z=%b", k, sm, a, b, q, r, z, eq, er, ez); end
      n_checks++; if (n !== (ez ? 1 : W + 1) || !bok) begin
        n_fail++; $display("FAIL rand%0d_timing: got latency %0d busy_ok %b expected %0d 1", k, n, bok, ez ? 1 : W + 1); end
    end
  endtask

  task automatic test_mid_start();
    int n; logic [W-1:0] q, r, eq, er; logic z, ez; bit bok;
    model(1'b0, 32'd1000003, 32'd97, eq, er, ez);
    @(negedge clock);
    launch(1'b0, 32'd1000003, 32'd97);
    wait_done(5, n, q, r, z, bok);
    n_checks++; if (q !== eq || r !== er) begin n_fail++; $display("FAIL mid_start: got q=%h r=%h expected q=%h r=%h", q, r, eq, er); end
    n_checks++; if (n !== W + 1 || !bok) begin n_fail++; $display("FAIL mid_start_timing: got %0d expected %0d", n, W + 1); end
    @(posedge clock); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_start_idle: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int n; logic [W-1:0] q, r, eq, er; logic z, ez; bit bok;
    @(negedge clock);
    launch(1'b0, 32'd12345, 32'd10);
    wait_done(0, n, q, r, z, bok);
    n_checks++; if (q !== 32'd1234 || r !== 32'd5) begin n_fail++; $display("FAIL b2b_first: got q=%h r=%h expected 000004d2 00000005", q, r); end
    model(1'b1, 32'hFFFF_FC18, 32'd7, eq, er, ez);
    launch(1'b1, 32'hFFFF_FC18, 32'd7);
    wait_done(0, n, q, r, z, bok);
    n_checks++; if (q !== eq || r !== er) begin n_fail++; $display("FAIL b2b_second: got q=%h r=%h expected q=%h r=%h", q, r, eq, er); end
    n_checks++; if (n !== W + 1 || !bok) begin n_fail++; $display("FAIL b2b_timing: got %0d expected %0d", n, W + 1); end
  endtask

  task automatic test_reset_mid();
    int n; logic [W-1:0] q, r; logic z; bit bok, saw_done;
    saw_done = 1'b0;
    @(negedge clock);
    launch(1'b0, 32'hDEAD_BEEF, 32'd3);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clock); reset_n = 1'b0;
    @(posedge clock); #1;
    n_checks++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_flags: got busy/done/dbz=%b%b%b expected 000", bus.busy, bus.done, bus.div_by_zero); end
    n_checks++; if (bus.quotient !== '0 || bus.remainder !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got q=%h r=%h expected 0 0", bus.quotient, bus.remainder); end
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL rstmid_nodone: got done/busy activity expected none"); end
    @(negedge clock);
    launch(1'b0, 32'd99, 32'd4);
    wait_done(0, n, q, r, z, bok);
    n_checks++; if (q !== 32'd24 || r !== 32'd3 || n !== W + 1) begin
      n_fail++; $display("FAIL rstmid_after: got q=%h r=%h lat=%0d expected 00000018 00000003 %0d", q, r, n, W + 1); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.dividend = '0; bus.divisor = '0;
    reset_n = 1'b0;
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
